// File: rtl/mem_write_scoreboard.sv
// ============================================================================
// Module   : mem_write_scoreboard
// Summary  : Scores CPU data-memory writes to a window of word addresses
//            against a loadable expected table; reports errors and duration.
//            Optional watchdog: define SCOREBOARD_TIMEOUT_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module mem_write_scoreboard #(
    parameter int          ADDR_W         = 30,
    parameter int          DATA_W         = 32,
    parameter int          NUM_CHECKS     = 14,
    parameter int          BASE_ADDR      = 0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    localparam int         IDX_W          = $clog2(NUM_CHECKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    output logic [7:0]        error_num,
    output logic [15:0]       duration,
    output logic              finish,
    output logic [IDX_W:0]    checked_cnt,
    output logic              first_err_valid,
    output logic [IDX_W-1:0]  first_err_idx
`ifdef SCOREBOARD_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] c_base = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] c_end  = c_base + (ADDR_W+1)'(NUM_CHECKS);
    localparam logic [IDX_W:0]  c_num  = (IDX_W+1)'(NUM_CHECKS);

    state_t                  r_state, w_state_nxt;
    logic [7:0]              r_error_num, w_err_nxt;
    logic [15:0]             r_duration, w_dur_nxt;
    logic [IDX_W:0]          r_checked_cnt, w_chk_nxt;
    logic                    r_first_err_valid, w_fv_nxt;
    logic [IDX_W-1:0]        r_first_err_idx, w_fi_nxt;
    logic [NUM_CHECKS-1:0]   r_seen, w_seen_nxt;
    logic                    r_wen_q;
    logic [DATA_W-1:0]       r_table [NUM_CHECKS];

    logic [ADDR_W:0]         w_addr_ext;
    logic                    w_accept;
    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_W-1:0]       w_data_mod;
    logic [DATA_W-1:0]       w_exp;
    logic                    w_mismatch;
    logic                    w_tab_we;

`ifdef SCOREBOARD_TIMEOUT_EN
    logic                    r_timeout, w_to_nxt;
    logic [8:0]              w_unseen;
    logic [8:0]              w_sum;
`endif

    assign w_addr_ext = {1'b0, addr};
    assign w_accept   = wen & ~r_wen_q;
    assign w_hit      = (w_addr_ext >= c_base) && (w_addr_ext < c_end);
    assign w_idx      = IDX_W'(w_addr_ext - c_base);
    assign w_tab_we   = (r_state == S_IDLE) && exp_we && ({1'b0, exp_idx} < c_num);

    // CPU stores little-endian; the table holds values in readable order.
    for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte_rev
        assign w_data_mod[8*i +: 8] = data[DATA_W-8-8*i +: 8];
    end

    // A table write to the index being scored in the same cycle wins.
    assign w_exp      = (w_tab_we && exp_idx == w_idx) ? exp_data : r_table[w_idx];
    assign w_mismatch = (w_data_mod != w_exp);

    always_ff @(posedge clk) begin
        if (w_tab_we) r_table[exp_idx] <= exp_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_error_num;
        w_dur_nxt   = r_duration;
        w_chk_nxt   = r_checked_cnt;
        w_fv_nxt    = r_first_err_valid;
        w_fi_nxt    = r_first_err_idx;
        w_seen_nxt  = r_seen;
`ifdef SCOREBOARD_TIMEOUT_EN
        w_to_nxt    = r_timeout;
        w_unseen    = '0;
        w_sum       = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_hit && w_idx == '0) begin
                    w_state_nxt   = S_CHECK;
                    w_seen_nxt[0] = 1'b1;
                    w_chk_nxt     = (IDX_W+1)'(1);
                    w_err_nxt     = w_mismatch ? 8'd1 : 8'd0;
                    if (w_mismatch) begin
                        w_fv_nxt = 1'b1;
                        w_fi_nxt = '0;
                    end
                end
            end
            S_CHECK: begin
                if (r_duration != 16'hFFFF) w_dur_nxt = r_duration + 16'd1;
                if (w_accept && w_hit && !r_seen[w_idx]) begin
                    w_seen_nxt[w_idx] = 1'b1;
                    w_chk_nxt         = r_checked_cnt + 1'b1;
                    if (w_mismatch) begin
                        if (r_error_num != 8'hFE) w_err_nxt = r_error_num + 8'd1;
                        if (!r_first_err_valid) begin
                            w_fv_nxt = 1'b1;
                            w_fi_nxt = w_idx;
                        end
                    end
                end
                if (w_chk_nxt == c_num) begin
                    w_state_nxt = S_REPORT;
                end
`ifdef SCOREBOARD_TIMEOUT_EN
                else if (r_duration == TIMEOUT_CYCLES) begin
                    // Every index never scored is charged as one error.
                    w_state_nxt = S_REPORT;
                    w_to_nxt    = 1'b1;
                    for (int i = 0; i < NUM_CHECKS; i++) begin
                        w_unseen = w_unseen + {8'b0, ~w_seen_nxt[i]};
                    end
                    w_sum     = {1'b0, w_err_nxt} + w_unseen;
                    w_err_nxt = (w_sum > 9'h0FE) ? 8'hFE : w_sum[7:0];
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_error_num       <= 8'hFF;
            r_duration        <= '0;
            r_checked_cnt     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_seen            <= '0;
            r_wen_q           <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_error_num       <= w_err_nxt;
            r_duration        <= w_dur_nxt;
            r_checked_cnt     <= w_chk_nxt;
            r_first_err_valid <= w_fv_nxt;
            r_first_err_idx   <= w_fi_nxt;
            r_seen            <= w_seen_nxt;
            r_wen_q           <= wen;
        end
    end

`ifdef SCOREBOARD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_timeout <= 1'b0;
        else      r_timeout <= w_to_nxt;
    end
    assign timeout = r_timeout;
`endif

    assign error_num       = r_error_num;
    assign duration        = r_duration;
    assign finish          = (r_state == S_REPORT);
    assign checked_cnt     = r_checked_cnt;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;

endmodule

`default_nettype wire
